// File: rtl/dac_load_sequencer_pkg.sv
// Shared types and defaults for the DAC load sequencer.
// State encoding, size defaults and timeout counter width.
package dac_seq_pkg;

  localparam int NUM_CH_D      = 32;
  localparam int ADDR_W_D      = 5;
  localparam int DATA_W_D      = 16;
  localparam int ACK_TIMEOUT_D = 255;

  function automatic int tmr_width(int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int TMR_W = tmr_width(ACK_TIMEOUT_D);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_LATCH    = 3'd2,
    S_LOAD     = 3'd3,
    S_WAIT_ACK = 3'd4,
    S_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/dac_load_sequencer_if.sv
// Load/acknowledge handshake between the sequencer
// and the serial DAC loader.
interface dac_load_sequencer_if
  import dac_seq_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_D,
  parameter int DATA_W = DATA_W_D
);

  logic [ADDR_W-1:0] dac_addr;
  logic [DATA_W-1:0] dac_dat;
  logic              dac_load;
  logic              dac_ack;

  modport master (
    output dac_addr,
    output dac_dat,
    output dac_load,
    input  dac_ack
  );

  modport slave (
    input  dac_addr,
    input  dac_dat,
    input  dac_load,
    output dac_ack
  );

endinterface

// File: rtl/dac_ack_timer.sv
// Saturating wait counter for the DAC acknowledge.
// expired is only asserted while counting is enabled.
module dac_ack_timer #(
  parameter int LIMIT = 255,
  parameter int W     = 8
) (
  input  logic clk_i,
  input  logic nrst_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [W-1:0] LIM = W'(LIMIT);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && cnt != LIM) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = enable && (cnt == LIM);

endmodule

// File: rtl/dac_load_sequencer.sv
// Sweeps the DAC shadow RAM into the serial loader and
// shares the RAM read port with housekeeping readout.
module dac_load_sequencer
  import dac_seq_pkg::*;
#(
  parameter int NUM_CH      = NUM_CH_D,
  parameter int ADDR_W      = ADDR_W_D,
  parameter int DATA_W      = DATA_W_D,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_D
) (
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              update_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] ram_raddr_o,
  input  logic [DATA_W-1:0] ram_dat_i,
  input  logic [ADDR_W-1:0] hk_raddr_i,
  output logic              hk_wait_o,
  dac_load_sequencer_if.master dac
);

  localparam int TW = tmr_width(ACK_TIMEOUT);
  localparam logic [ADDR_W-1:0] LAST_CH = ADDR_W'(NUM_CH - 1);

  state_t            state;
  logic [ADDR_W-1:0] ch;
  logic              pending;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dat_q;
  logic              load_q;
  logic              expired;
  logic              last_ch;

  assign last_ch = (ch == LAST_CH);

  dac_ack_timer #(
    .LIMIT (ACK_TIMEOUT),
    .W     (TW)
  ) u_timer (
    .clk_i   (clk_i),
    .nrst_i  (nrst_i),
    .clear   (state == S_LOAD),
    .enable  (state == S_WAIT_ACK),
    .expired (expired)
  );

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state   <= S_IDLE;
      ch      <= '0;
      pending <= 1'b0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      load_q  <= 1'b0;
      addr_q  <= '0;
      dat_q   <= '0;
    end else begin
      done_o <= 1'b0;
      load_q <= 1'b0;
      busy_o <= 1'b1;
      if (state != S_IDLE && update_i) begin
        pending <= 1'b1;
      end
      unique case (state)
        S_IDLE: begin
          busy_o <= update_i;
          if (update_i) begin
            ch    <= '0;
            err_o <= 1'b0;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          state <= S_LATCH;
        end
        S_LATCH: begin
          dat_q  <= ram_dat_i;
          addr_q <= ch;
          load_q <= 1'b1;
          state  <= S_LOAD;
        end
        S_LOAD: begin
          state <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (dac.dac_ack || expired) begin
            if (!dac.dac_ack) begin
              err_o <= 1'b1;
            end
            if (last_ch) begin
              done_o <= 1'b1;
              state  <= S_DONE;
            end else begin
              ch    <= ch + 1'b1;
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          // a request arriving in DONE joins this restart
          pending <= 1'b0;
          busy_o  <= pending || update_i;
          if (pending || update_i) begin
            ch    <= '0;
            err_o <= 1'b0;
            state <= S_FETCH;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign hk_wait_o   = (state == S_FETCH);
  assign ram_raddr_o = hk_wait_o ? ch : hk_raddr_i;

  assign dac.dac_addr = addr_q;
  assign dac.dac_dat  = dat_q;
  assign dac.dac_load = load_q;

endmodule

// File: doc/dac_load_sequencer.md
# dac_load_sequencer

Walks the 32-entry DAC shadow RAM and hands each channel's value to the serial DAC loader, one channel at a time with an acknowledge handshake. Also shares the RAM's single read port with the housekeeping readout path. Sits between the local-bus register block and the DAC serializer. The bus interface's DAC update strobe starts a sweep. The sequencer's busy flag is what the bus interface reports as DAC busy.

## Interface
Parameters:
- NUM_CH, 32, number of DAC channels swept per update
- ADDR_W, 5, RAM/DAC address width (2^ADDR_W ≥ NUM_CH)
- DATA_W, 16, DAC word width
- ACK_TIMEOUT, 255, cycles to wait in WAIT_ACK before declaring a channel failed

Ports:
- clk_i  in  1  system clock (33 MHz domain); the single clock
- nrst_i  in  1  reset; asynchronous, active-low
- update_i  in  1  one-cycle request to reload all channels
- busy_o  out  1  high from the cycle after an update is accepted until the sweep completes
- done_o  out  1  one-cycle pulse when a sweep completes
- err_o  out  1  sticky; set on any ack timeout; cleared when the next update is accepted
- ram_raddr_o  out  ADDR_W  shadow RAM read address
- ram_dat_i  in  DATA_W  shadow RAM read data; registered RAM, 1-cycle latency
- hk_raddr_i  in  ADDR_W  housekeeping read address
- hk_wait_o  out  1  housekeeping must not use the RAM data in the following cycle
- dac_addr_o  out  ADDR_W  channel being loaded
- dac_dat_o  out  DATA_W  value being loaded
- dac_load_o  out  1  one-cycle strobe to the serializer
- dac_ack_i  in  1  one-cycle pulse from the serializer: word shifted out

## Operation
States are IDLE, FETCH, LATCH, LOAD, WAIT_ACK and DONE.
- **IDLE.** update_i=1 sets ch=0, clears err_o and goes to FETCH.
- **FETCH.** ram_raddr_o=ch. Always goes to LATCH.
- **LATCH.** Captures ram_dat_i into dac_dat_o and ch into dac_addr_o. Goes to LOAD.
- **LOAD.** dac_load_o=1 for this cycle only. Clears the timeout counter. Goes to WAIT_ACK.
- **WAIT_ACK.**
  - dac_ack_i=1: if ch==NUM_CH-1 go to DONE; otherwise ch+=1 and go to FETCH.
  - Timeout counter reaches ACK_TIMEOUT: set err_o and advance exactly as for an ack. The failed channel is skipped.
  - Ack and timeout in the same cycle count as an ack; err_o is not set.
- **DONE.** done_o=1. If pending=1, clear pending, set ch=0, clear err_o and go to FETCH. Otherwise go to IDLE.

Pending updates:
- update_i in any state other than IDLE sets pending.
- Any number of requests during a sweep collapse into one restart.

Handshake and arbitration rules:
- dac_ack_i outside WAIT_ACK is ignored.
- busy_o is a registered output: busy_o = (state != IDLE) || pending.
- RAM port mux: ram_raddr_o = ch in FETCH, otherwise hk_raddr_i. The sequencer has absolute priority.
- hk_wait_o = (state==FETCH).

Arithmetic:
- ch is ADDR_W bits. There is no wrap past NUM_CH-1; the sweep terminates there.
- The timeout counter is ceil(log2(ACK_TIMEOUT+1)) bits and saturates.

Reset:
- nrst_i low at any time forces IDLE, ch=0 and pending=0.
- All outputs go to 0: busy_o, done_o, err_o, dac_load_o, hk_wait_o, dac_addr_o, dac_dat_o=0; ram_raddr_o follows hk_raddr_i.
- An interrupted sweep is not resumed.

## Timing
- update_i is sampled at edge 0. At cycle 1 the state is FETCH, busy_o=1 and hk_wait_o=1.
- Cycle 2 is LATCH. Cycle 3 is LOAD with dac_load_o=1; dac_addr_o and dac_dat_o are valid from cycle 3 and held until the next LATCH.
- The earliest accepted ack is at cycle 4. With ack at the first opportunity, each channel takes 4 cycles.
- A full sweep with immediate acks takes 128 cycles plus 1 for DONE. done_o is at cycle 129, and busy_o falls at cycle 130 if nothing is pending.
- Housekeeping data is valid 1 cycle after its address unless hk_wait_o was high in the address cycle. In that case housekeeping re-presents the address.
- All outputs are registered except ram_raddr_o and hk_wait_o, which are decoded from registered state.

## Structure
- Package dac_seq_pkg holds:
  - the state enum (3 bits, IDLE=0)
  - default constants for NUM_CH, ADDR_W, DATA_W and ACK_TIMEOUT
  - the localparam for timeout counter width
- Sub-module dac_ack_timer contains the saturating counter. Its ports are clear, enable and expired.
- All FSM, channel and arbitration logic stays in the top module.

## Test plan
- **Basic sweep.** Preload RAM[n]=0x1000+n, pulse update_i, and ack 2 cycles after each load. Expect 32 loads, with dac_addr_o=0..31 in order and dac_dat_o=0x1000..0x101F. Expect one done_o pulse, busy_o falling the cycle after DONE, and err_o=0.
- **Collapsed updates.** Pulse update_i three times during channel 10. Expect exactly one restart from ch=0 immediately after DONE, with busy_o continuously high. Expect 64 loads total and two done_o pulses.
- **Timeout.** Withhold the ack on ch=5 only. Expect err_o set ACK_TIMEOUT cycles after that load, ch=6 loaded next, and the sweep completing. err_o stays 1 until the next accepted update clears it.
- **Ack/timeout coincidence and stray ack.** Ack exactly at the expiry cycle: expect err_o=0. Pulse dac_ack_i while in IDLE and in LATCH: expect no state change.
- **Arbitration.** Hold hk_raddr_i=7 throughout a sweep. Expect ram_raddr_o=ch and hk_wait_o=1 only in FETCH cycles, and ram_raddr_o=7 in every other cycle.
- **Reset mid-sweep.** Drop nrst_i during ch=20 WAIT_ACK. Expect all outputs 0 immediately, with the state in IDLE. After release, the next update starts at ch=0.
